ring_rx_checker: RTL

- Receive-side companion to the 3-bit ring-counter pad output.
- Samples a one-hot rotating pattern arriving on user I/O inputs (from an external board or loopback) and synchronizes it.
- Decodes the hot-bit position, locks onto a legal rotation sequence, and flags and counts sequence errors.
- Sits in the user project beside the ring-counter core, clocked from the same Wishbone clock.

---
 rtl/ring_rx_checker.sv | 100 ++++++++++
 1 files changed

// File: rtl/ring_rx_checker.sv
// ring_rx_checker: synchronizes a rotating one-hot ring pattern, locks onto its sequence and counts errors.
//   clk        : single rising-edge clock
//   ori        : asynchronous active-high reset
//   sample_en  : compare-stage enable; low freezes the checker state
//   ring_in    : raw ring pattern from the pads, asynchronous to clk
//   err_clr    : synchronous clear of err_count (wins over a same-edge error)
//   locked     : checker is in LOCKED
//   pos        : hot-bit index of the last compared sample (0 if not one-hot)
//   pos_valid  : last compared sample was exactly one-hot
//   err_pulse  : one-cycle pulse on a sequence error while LOCKED
//   wrap_pulse : one-cycle pulse when a locked ring returns to its start pattern
//   err_count  : saturating error count
module ring_rx_checker #(
    parameter int WIDTH      = 3,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8,
    localparam int PW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 ori,
    input  logic                 sample_en,
    input  logic [WIDTH-1:0]     ring_in,
    input  logic                 err_clr,
    output logic                 locked,
    output logic [PW-1:0]        pos,
    output logic                 pos_valid,
    output logic                 err_pulse,
    output logic                 wrap_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);
    typedef enum logic {HUNT, LOCKED} state_t;

    localparam logic [3:0]           LC    = 4'(LOCK_COUNT);
    localparam logic [WIDTH-1:0]     START = WIDTH'(1) << (WIDTH - 1);
    localparam logic [ERR_CNT_W-1:0] SAT   = '1;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       q1_q, q2_q, prev_q, exp_w;
    logic [3:0]             cnt_q, cnt_d;
    logic [PW-1:0]          pos_d;
    logic                   one_hot, legal, err_d, wrap_d;
    logic [ERR_CNT_W-1:0]   err_count_d;

    // The ring rotates right: 100 -> 010 -> 001 -> 100.
    assign exp_w   = {prev_q[0], prev_q[WIDTH-1:1]};
    assign one_hot = $onehot(q2_q);
    assign legal   = one_hot && (q2_q == exp_w);
    assign locked  = (state_q == LOCKED);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        pos_d   = '0;
        for (int i = 0; i < WIDTH; i++)
            if (one_hot && q2_q[i]) pos_d = PW'(i);
        if (state_q == HUNT) begin
            cnt_d   = !legal ? '0 : (cnt_q + 4'd1 == LC) ? '0 : cnt_q + 4'd1;
            state_d = (legal && cnt_q + 4'd1 == LC) ? LOCKED : HUNT;
        end else if (!legal) begin
            err_d   = 1'b1;
            state_d = HUNT;
            cnt_d   = '0;
        end else begin
            wrap_d  = (q2_q == START);
        end
        // Clear wins over a coincident error; the error pulse still fires.
        err_count_d = err_clr ? '0 :
                      (sample_en && err_d && err_count != SAT) ? err_count + 1'b1 : err_count;
    end

    always_ff @(posedge clk or posedge ori) begin
        if (ori) begin
            q1_q       <= '0;
            q2_q       <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            state_q    <= HUNT;
            pos        <= '0;
            pos_valid  <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
        end else begin
            q1_q       <= ring_in;
            q2_q       <= q1_q;
            err_count  <= err_count_d;
            err_pulse  <= sample_en && err_d;
            wrap_pulse <= sample_en && wrap_d;
            if (sample_en) begin
                prev_q    <= q2_q;
                cnt_q     <= cnt_d;
                state_q   <= state_d;
                pos       <= pos_d;
                pos_valid <= one_hot;
            end
        end
    end
endmodule
